ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX->MEM pipeline stage for the pipelined core, replacing the plain reset-only flop.

---
 rtl/ex_mem_pipe_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, stall and flush.
// Define EX_MEM_SKID_EN for a one-entry skid buffer and a registered ready_oe.
module ex_mem_pipe_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              valid_ie,
    output logic              ready_oe,
    input  logic              zero_ie,
    input  logic [WIDTH-1:0]  alu_out_ie,
    input  logic [WIDTH-1:0]  write_data_ie,
    input  logic [REG_AW-1:0] dst_reg_addr_ie,
    input  logic [WIDTH-1:0]  pc_branch_ie,
    input  logic              reg_write_ie,
    input  logic              mem_write_ie,
    input  logic              mem_to_reg_ie,
    input  logic              branch_ie,
    input  logic              ready_im,
    output logic              valid_om,
    output logic              zero_om,
    output logic [WIDTH-1:0]  alu_out_om,
    output logic [WIDTH-1:0]  write_data_om,
    output logic [REG_AW-1:0] dst_reg_addr_om,
    output logic [WIDTH-1:0]  pc_branch_om,
    output logic              reg_write_om,
    output logic              mem_write_om,
    output logic              mem_to_reg_om,
    output logic              branch_om
);

    typedef struct packed {
        logic              zero;
        logic [WIDTH-1:0]  alu_out;
        logic [WIDTH-1:0]  write_data;
        logic [REG_AW-1:0] dst;
        logic [WIDTH-1:0]  pc_branch;
    } data_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    data_t in_d, main_d;
    ctrl_t in_c, main_c;
    logic  valid_q;
    logic  load_in;
    logic  drain;

    assign in_d = '{zero: zero_ie, alu_out: alu_out_ie,
                    write_data: write_data_ie, dst: dst_reg_addr_ie,
                    pc_branch: pc_branch_ie};
    assign in_c = '{reg_write: reg_write_ie, mem_write: mem_write_ie,
                    mem_to_reg: mem_to_reg_ie, branch: branch_ie};

    assign load_in = valid_ie & ready_oe;
    assign drain   = valid_q & ready_im;

`ifdef EX_MEM_SKID_EN
    data_t skid_d;
    ctrl_t skid_c;
    logic  skid_valid;

    // ready comes straight off the skid flop, so MEM never combinationally reaches EX
    assign ready_oe = ~skid_valid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_d     <= '0;
            main_c     <= '0;
            valid_q    <= 1'b0;
            skid_d     <= '0;
            skid_c     <= '0;
            skid_valid <= 1'b0;
        end else if (flush_i) begin
            main_c     <= '0;
            valid_q    <= 1'b0;
            skid_c     <= '0;
            skid_valid <= 1'b0;
        end else if (drain && skid_valid) begin
            main_d     <= skid_d;
            main_c     <= skid_c;
            skid_c     <= '0;
            skid_valid <= 1'b0;
        end else if (load_in && valid_q && !ready_im) begin
            skid_d     <= in_d;
            skid_c     <= in_c;
            skid_valid <= 1'b1;
        end else if (load_in) begin
            main_d  <= in_d;
            main_c  <= in_c;
            valid_q <= 1'b1;
        end else if (drain) begin
            main_c  <= '0;
            valid_q <= 1'b0;
        end
    end
`else
    assign ready_oe = ready_im | ~valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_d  <= '0;
            main_c  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            main_c  <= '0;
            valid_q <= 1'b0;
        end else if (load_in) begin
            main_d  <= in_d;
            main_c  <= in_c;
            valid_q <= 1'b1;
        end else if (drain) begin
            main_c  <= '0;
            valid_q <= 1'b0;
        end
    end
`endif

    assign valid_om        = valid_q;
    assign zero_om         = main_d.zero;
    assign alu_out_om      = main_d.alu_out;
    assign write_data_om   = main_d.write_data;
    assign dst_reg_addr_om = main_d.dst;
    assign pc_branch_om    = main_d.pc_branch;
    assign reg_write_om    = main_c.reg_write;
    assign mem_write_om    = main_c.mem_write;
    assign mem_to_reg_om   = main_c.mem_to_reg;
    assign branch_om       = main_c.branch;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: scoreboard of accepted words, monitor on drains,
// plus directed reset/stream/stall/flush/bubble checks and a random phase.
module tb_ex_mem_pipe_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        valid_ie;
    logic        ready_oe;
    logic        zero_ie;
    logic [31:0] alu_out_ie, write_data_ie, pc_branch_ie;
    logic [4:0]  dst_reg_addr_ie;
    logic        reg_write_ie, mem_write_ie, mem_to_reg_ie, branch_ie;
    logic        ready_im;
    logic        valid_om;
    logic        zero_om;
    logic [31:0] alu_out_om, write_data_om, pc_branch_om;
    logic [4:0]  dst_reg_addr_om;
    logic        reg_write_om, mem_write_om, mem_to_reg_om, branch_om;

    logic [105:0] in_w;
    logic [105:0] out_w;
    logic [3:0]   ctrl_o;

    logic [105:0] q[$];
    int total = 0;
    int pass  = 0;

    always #5 clk_i = ~clk_i;

    assign {zero_ie, alu_out_ie, write_data_ie, dst_reg_addr_ie, pc_branch_ie,
            reg_write_ie, mem_write_ie, mem_to_reg_ie, branch_ie} = in_w;
    assign out_w = {zero_om, alu_out_om, write_data_om, dst_reg_addr_om,
                    pc_branch_om, reg_write_om, mem_write_om, mem_to_reg_om,
                    branch_om};
    assign ctrl_o = {reg_write_om, mem_write_om, mem_to_reg_om, branch_om};

    ex_mem_pipe_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_ie(valid_ie), .ready_oe(ready_oe),
        .zero_ie(zero_ie), .alu_out_ie(alu_out_ie),
        .write_data_ie(write_data_ie), .dst_reg_addr_ie(dst_reg_addr_ie),
        .pc_branch_ie(pc_branch_ie), .reg_write_ie(reg_write_ie),
        .mem_write_ie(mem_write_ie), .mem_to_reg_ie(mem_to_reg_ie),
        .branch_ie(branch_ie), .ready_im(ready_im),
        .valid_om(valid_om), .zero_om(zero_om), .alu_out_om(alu_out_om),
        .write_data_om(write_data_om), .dst_reg_addr_om(dst_reg_addr_om),
        .pc_branch_om(pc_branch_om), .reg_write_om(reg_write_om),
        .mem_write_om(mem_write_om), .mem_to_reg_om(mem_to_reg_om),
        .branch_om(branch_om)
    );

    function automatic logic [105:0] mk(logic [31:0] v, logic [3:0] c);
        return {v[0], v, ~v, v[4:0], v + 32'h4000, c};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // expected side: every accepted word, in acceptance order
    always @(negedge clk_i) begin
        if (reset_i || flush_i) q.delete();
        else if (valid_ie && ready_oe) q.push_back(in_w);
    end

    // checking side: every drain must match the oldest accepted word
    always @(negedge clk_i) begin
        #1;
        if (!reset_i && valid_om && ready_im) begin
            if (q.size() == 0) chk("pop_empty", 128'(1), 128'(0));
            else chk("sb_word", 128'(out_w), 128'(q.pop_front()));
        end
        if (!valid_om) chk("bubble_ctrl", 128'(ctrl_o), 128'(0));
    end

    task automatic cyc(bit v, logic [105:0] w, bit r, bit f);
        valid_ie = v;
        in_w     = w;
        ready_im = r;
        flush_i  = f;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i  = 1'b1;
        flush_i  = 1'b0;
        valid_ie = 1'b0;
        ready_im = 1'b0;
        in_w     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk("rst_valid", 128'(valid_om), 128'(0));
        chk("rst_ready", 128'(ready_oe), 128'(1));
        chk("rst_out", 128'(out_w), 128'(0));

        // reset mid-stream takes effect between edges
        cyc(1, mk(32'h1234, 4'b1010), 0, 0);
        chk("t1_valid", 128'(valid_om), 128'(1));
        chk("t1_alu", 128'(alu_out_om), 128'h1234);
        valid_ie = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("t1_async_valid", 128'(valid_om), 128'(0));
        chk("t1_async_out", 128'(out_w), 128'(0));
        @(posedge clk_i);
        #1 reset_i = 1'b0;

        // stream of four
        for (int i = 0; i < 4; i++) begin
            cyc(1, mk(32'h10 + 32'(i), 4'(i)), 1, 0);
            chk("t2_valid", 128'(valid_om), 128'(1));
            chk("t2_alu", 128'(alu_out_om), 128'(32'h10 + 32'(i)));
        end
        cyc(0, '0, 1, 0);
        chk("t2_end", 128'(valid_om), 128'(0));

        // stall holding 0xAA, 0xBB offered
        cyc(1, mk(32'hAA, 4'b1001), 1, 0);
        for (int i = 0; i < 3; i++) begin
            valid_ie = 1'b1;
            in_w     = mk(32'hBB, 4'b0110);
            ready_im = 1'b0;
            #1;
`ifdef EX_MEM_SKID_EN
            chk("t3_ready", 128'(ready_oe), 128'(i == 0));
`else
            chk("t3_ready", 128'(ready_oe), 128'(0));
`endif
            @(posedge clk_i);
            #1;
            chk("t3_hold_alu", 128'(alu_out_om), 128'hAA);
            chk("t3_hold_valid", 128'(valid_om), 128'(1));
        end
`ifdef EX_MEM_SKID_EN
        cyc(0, '0, 1, 0);
`else
        cyc(1, mk(32'hBB, 4'b0110), 1, 0);
`endif
        chk("t3_next", 128'(alu_out_om), 128'hBB);
        cyc(0, '0, 1, 0);
        chk("t3_done", 128'(valid_om), 128'(0));

        // flush with a live load on the same edge
        cyc(1, mk(32'hC0, 4'b0000), 1, 0);
        cyc(1, mk(32'hC1, 4'b0000), 0, 0);
        cyc(1, mk(32'hFC2, 4'b1100), 0, 1);
        chk("t4_valid", 128'(valid_om), 128'(0));
        chk("t4_rw", 128'(reg_write_om), 128'(0));
        chk("t4_mw", 128'(mem_write_om), 128'(0));
        chk("t4_ready", 128'(ready_oe), 128'(1));
        chk("t4_data_hold", 128'(alu_out_om), 128'hC0);
        cyc(0, '0, 1, 0);
        chk("t4_skid_empty", 128'(valid_om), 128'(0));

        // one-cycle bubble
        cyc(1, mk(32'h20, 4'b1111), 1, 0);
        cyc(1, mk(32'h21, 4'b1111), 1, 0);
        cyc(0, mk(32'h99, 4'b1111), 1, 0);
        chk("t5_bubble_valid", 128'(valid_om), 128'(0));
        chk("t5_bubble_ctrl", 128'(ctrl_o), 128'(0));
        cyc(1, mk(32'h22, 4'b1111), 1, 0);
        chk("t5_resume", 128'(alu_out_om), 128'h22);
        chk("t5_resume_v", 128'(valid_om), 128'(1));
        cyc(0, '0, 1, 0);

        // random handshake
        for (int n = 0; n < 1000; n++)
            cyc(1'($urandom_range(0, 1)), mk(32'h100 + 32'(n), 4'($urandom)),
                1'($urandom_range(0, 1)), 0);
        repeat (4) cyc(0, '0, 1, 0);
        chk("t6_drained", 128'(q.size()), 128'(0));
        chk("t6_idle", 128'(valid_om), 128'(0));

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
